// File: rtl/cmflg_pkg.sv
// Shared definitions for the cmflg gate and its sweep controller.
//   - function-select codes (BUF..XNOR), also used by the gate itself
//   - sweep controller state encoding
//   - find_enabled(): lowest vector index >= from whose function is enabled
package cmflg_pkg;

  localparam logic [2:0] FN_BUF  = 3'b000;
  localparam logic [2:0] FN_INV  = 3'b001;
  localparam logic [2:0] FN_AND  = 3'b010;
  localparam logic [2:0] FN_NAND = 3'b011;
  localparam logic [2:0] FN_OR   = 3'b100;
  localparam logic [2:0] FN_NOR  = 3'b101;
  localparam logic [2:0] FN_XOR  = 3'b110;
  localparam logic [2:0] FN_XNOR = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } sweep_state_e;

  // Vector index is {s,a,b}; an index is enabled when mask[s] is set.
  // Result bit 5 flags "found"; bits 4:0 are the index. A 6-bit 'from'
  // lets callers ask for "after 31" (from=32) and get not-found.
  function automatic logic [5:0] find_enabled(input logic [5:0] from,
                                               input logic [7:0] mask);
    logic [5:0] r;
    logic [4:0] iv;
    r = '0;
    for (int i = 31; i >= 0; i--) begin
      iv = 5'(i);
      if ((6'(i) >= from) && mask[iv[4:2]]) r = {1'b1, iv};
    end
    return r;
  endfunction

endpackage

// File: rtl/cmflg_ref_model.sv
// Combinational golden model of the cmflg gate.
// Ports:
//   a_i, b_i  logic inputs
//   s_i       function select (BUF..XNOR)
//   y_exp_o   expected gate output
module cmflg_ref_model
  import cmflg_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  input  logic [2:0] s_i,
  output logic       y_exp_o
);

  always_comb begin
    y_exp_o = 1'b0;
    case (s_i)
      FN_BUF:  y_exp_o = a_i;
      FN_INV:  y_exp_o = ~a_i;
      FN_AND:  y_exp_o = a_i & b_i;
      FN_NAND: y_exp_o = ~(a_i & b_i);
      FN_OR:   y_exp_o = a_i | b_i;
      FN_NOR:  y_exp_o = ~(a_i | b_i);
      FN_XOR:  y_exp_o = a_i ^ b_i;
      FN_XNOR: y_exp_o = ~(a_i ^ b_i);
      default: y_exp_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cmflg_sweep_ctrl.sv
// Self-test sweep controller for a cmflg gate instance.
// Walks {s,a,b} through every enabled function code and input pair, holds
// each vector SETTLE_CYCLES cycles, then compares the returned y against
// the golden model and accumulates results.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start_i             begin a sweep (IDLE/DONE only)
//   abort_i             return to IDLE, results kept, vector cleared
//   y_i                 output of gate under test
//   a_o, b_o, s_o       registered stimulus to gate
//   busy_o              sweep in progress
//   done_o, pass_o      sweep finished / finished with zero errors
//   err_cnt_o           mismatch count
//   fail_valid_o        first failing vector captured in fail_vec_o ({s,a,b})
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_IDLE   | waiting for start, stimulus at 0
// ST_SETTLE | vector applied, counting down settle time
// ST_CHECK  | sample y, compare, advance to next vector
// ST_DONE   | sweep finished, results held until start/abort
module cmflg_sweep_ctrl
  import cmflg_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [7:0]  FUNC_MASK     = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       y_i,
  output logic       a_o,
  output logic       b_o,
  output logic [2:0] s_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic [5:0] err_cnt_o,
  output logic       fail_valid_o,
  output logic [4:0] fail_vec_o
);

  localparam int unsigned   CW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

  sweep_state_e  state_q, state_d;
  logic [4:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    err_q, err_d;
  logic          fv_q, fv_d;
  logic [4:0]    fvec_q, fvec_d;

  logic          y_exp;
  logic          mismatch;
  logic [5:0]    first_en;
  logic [5:0]    next_en;

  cmflg_ref_model u_ref (
    .a_i     (idx_q[1]),
    .b_i     (idx_q[0]),
    .s_i     (idx_q[4:2]),
    .y_exp_o (y_exp)
  );

  assign first_en = find_enabled(6'd0, FUNC_MASK);
  assign next_en  = find_enabled({1'b0, idx_q} + 6'd1, FUNC_MASK);
  // Case inequality so an undriven/unknown y counts as a failure.
  assign mismatch = (y_i !== y_exp);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fv_d    = fv_q;
    fvec_d  = fvec_q;

    if (abort_i) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            err_d  = '0;
            fv_d   = 1'b0;
            fvec_d = '0;
            if (first_en[5]) begin
              idx_d   = first_en[4:0];
              cnt_d   = CNT_LOAD;
              state_d = ST_SETTLE;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
        ST_SETTLE: begin
          if (cnt_q == '0) state_d = ST_CHECK;
          else             cnt_d   = cnt_q - 1'b1;
        end
        ST_CHECK: begin
          if (mismatch) begin
            err_d = err_q + 6'd1;
            if (!fv_q) begin
              fv_d   = 1'b1;
              fvec_d = idx_q;
            end
          end
          if (next_en[5]) begin
            idx_d   = next_en[4:0];
            cnt_d   = CNT_LOAD;
            state_d = ST_SETTLE;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      fvec_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fvec_q  <= fvec_d;
    end
  end

  assign a_o          = idx_q[1];
  assign b_o          = idx_q[0];
  assign s_o          = idx_q[4:2];
  assign busy_o       = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
  assign done_o       = (state_q == ST_DONE);
  assign pass_o       = done_o && (err_q == 6'd0);
  assign err_cnt_o    = err_q;
  assign fail_valid_o = fv_q;
  assign fail_vec_o   = fvec_q;

endmodule

// File: tb/tb_cmflg_sweep_ctrl.sv
// Bench for cmflg_sweep_ctrl: three instances (full mask / AND-only with
// settle 3 / empty mask) each driven by a truth-table model of the gate,
// with random per-vector fault maps flipping y.
module tb_cmflg_sweep_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Truth table of all 8 functions, bit index = {s,a,b}.
  localparam logic [31:0] TT_ALL = {4'b1001, 4'b0110, 4'b0001, 4'b1110,
                                    4'b0111, 4'b1000, 4'b0011, 4'b1100};

  function automatic logic gate(input logic [4:0] idx);
    logic [31:0] t;
    t = TT_ALL;
    return t[idx];
  endfunction

  // instance 0: full mask, settle 1
  logic st0 = 1'b0, ab0 = 1'b0, y0, a0, b0, bz0, dn0, ps0, fv0;
  logic [2:0] s0;
  logic [5:0] ec0;
  logic [4:0] fvec0;
  logic zero0 = 1'b0;
  logic [31:0] emap0 = '0;
  // instance 1: AND only, settle 3
  logic st1 = 1'b0, y1, a1, b1, bz1, dn1, ps1, fv1;
  logic [2:0] s1;
  logic [5:0] ec1;
  logic [4:0] fvec1;
  logic [31:0] emap1 = '0;
  // instance 2: empty mask
  logic st2 = 1'b0, y2, a2, b2, bz2, dn2, ps2, fv2;
  logic [2:0] s2;
  logic [5:0] ec2;
  logic [4:0] fvec2;

  assign y0 = zero0 ? 1'b0 : (gate({s0, a0, b0}) ^ emap0[{s0, a0, b0}]);
  assign y1 = gate({s1, a1, b1}) ^ emap1[{s1, a1, b1}];
  assign y2 = gate({s2, a2, b2});

  cmflg_sweep_ctrl #(.SETTLE_CYCLES(1), .FUNC_MASK(8'hFF)) dut0 (
    .clk(clk), .rst_n(rst_n), .start_i(st0), .abort_i(ab0), .y_i(y0),
    .a_o(a0), .b_o(b0), .s_o(s0), .busy_o(bz0), .done_o(dn0), .pass_o(ps0),
    .err_cnt_o(ec0), .fail_valid_o(fv0), .fail_vec_o(fvec0));

  cmflg_sweep_ctrl #(.SETTLE_CYCLES(3), .FUNC_MASK(8'b0000_0100)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(st1), .abort_i(1'b0), .y_i(y1),
    .a_o(a1), .b_o(b1), .s_o(s1), .busy_o(bz1), .done_o(dn1), .pass_o(ps1),
    .err_cnt_o(ec1), .fail_valid_o(fv1), .fail_vec_o(fvec1));

  cmflg_sweep_ctrl #(.SETTLE_CYCLES(1), .FUNC_MASK(8'h00)) dut2 (
    .clk(clk), .rst_n(rst_n), .start_i(st2), .abort_i(1'b0), .y_i(y2),
    .a_o(a2), .b_o(b2), .s_o(s2), .busy_o(bz2), .done_o(dn2), .pass_o(ps2),
    .err_cnt_o(ec2), .fail_valid_o(fv2), .fail_vec_o(fvec2));

  // Record each distinct vector presented while busy.
  int q0[$];
  int q1[$];
  int moves2 = 0;
  always @(negedge clk) begin
    if (bz0 && (q0.size() == 0 || q0[$] != int'({s0, a0, b0}))) q0.push_back(int'({s0, a0, b0}));
    if (bz1 && (q1.size() == 0 || q1[$] != int'({s1, a1, b1}))) q1.push_back(int'({s1, a1, b1}));
    if (bz2 || ({s2, a2, b2} != 5'd0)) moves2 <= moves2 + 1;
  end

  function automatic logic done_of(input int w);
    case (w)
      0:       return dn0;
      1:       return dn1;
      default: return dn2;
    endcase
  endfunction

  // Expected results of one sweep from the gate rules and the fault map.
  function automatic void expect_for(input logic [7:0] mask, input logic zero,
                                     input logic [31:0] em, output int e,
                                     output logic fv, output logic [4:0] fvec);
    e = 0; fv = 1'b0; fvec = '0;
    for (int i = 0; i < 32; i++) begin
      logic [4:0] iv;
      logic yg, yd;
      iv = 5'(i);
      yg = gate(iv);
      yd = zero ? 1'b0 : (yg ^ em[i]);
      if (mask[iv[4:2]] && (yd != yg)) begin
        e++;
        if (!fv) begin fv = 1'b1; fvec = iv; end
      end
    end
  endfunction

  // Pulse start for one cycle and count edges until done (bounded).
  task automatic start_and_wait(input int which, input int budget, output int cyc);
    @(posedge clk); #1;
    case (which)
      0:       st0 = 1'b1;
      1:       st1 = 1'b1;
      default: st2 = 1'b1;
    endcase
    cyc = 0;
    do begin
      @(posedge clk); #1;
      st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
      cyc++;
    end while (!done_of(which) && cyc < budget);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if ({a0, b0, s0} !== 5'd0) begin bad++; $display("FAIL reset_abs got=%0d exp=0", {a0, b0, s0}); end
    total++; if (bz0 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bz0); end
    total++; if (dn0 !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", dn0); end
    total++; if (ps0 !== 1'b0) begin bad++; $display("FAIL reset_pass got=%b exp=0", ps0); end
    total++; if (ec0 !== 6'd0) begin bad++; $display("FAIL reset_err got=%0d exp=0", ec0); end
    total++; if ({fv0, fvec0} !== 6'd0) begin bad++; $display("FAIL reset_fail got=%b/%b exp=0", fv0, fvec0); end
    total++; if ({bz1, dn1, bz2, dn2} !== 4'd0) begin bad++; $display("FAIL reset_others got=%b exp=0000", {bz1, dn1, bz2, dn2}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_full(input logic zero, input logic [31:0] em);
    int cyc, e, base;
    logic fv;
    logic [4:0] fvec;
    bit ord_ok;
    zero0 = zero; emap0 = em;
    base = q0.size();
    expect_for(8'hFF, zero, em, e, fv, fvec);
    start_and_wait(0, 200, cyc);
    total++; if (cyc !== 65) begin bad++; $display("FAIL full_latency got=%0d exp=65", cyc); end
    total++; if (ps0 !== (e == 0)) begin bad++; $display("FAIL full_pass got=%b exp=%b", ps0, (e == 0)); end
    total++; if (ec0 !== 6'(e)) begin bad++; $display("FAIL full_err got=%0d exp=%0d", ec0, e); end
    total++; if (fv0 !== fv) begin bad++; $display("FAIL full_fail_valid got=%b exp=%b", fv0, fv); end
    total++; if (fvec0 !== fvec) begin bad++; $display("FAIL full_fail_vec got=%b exp=%b", fvec0, fvec); end
    ord_ok = (q0.size() - base == 32);
    if (ord_ok) for (int k = 0; k < 32; k++) if (q0[base + k] != k) ord_ok = 1'b0;
    total++; if (!ord_ok) begin bad++; $display("FAIL full_order got=%0d vectors exp=32 ascending", q0.size() - base); end
    total++; if ({s0, a0, b0} !== 5'd31) begin bad++; $display("FAIL full_last_vec got=%0d exp=31", {s0, a0, b0}); end
  endtask

  task automatic test_stuck_zero();
    test_full(1'b1, 32'h0);
    total++; if (ec0 !== 6'd16) begin bad++; $display("FAIL stuck0_err got=%0d exp=16", ec0); end
    total++; if (fvec0 !== 5'b00010) begin bad++; $display("FAIL stuck0_vec got=%b exp=00010", fvec0); end
    zero0 = 1'b0;
  endtask

  task automatic test_random_errors();
    for (int r = 0; r < 4; r++) test_full(1'b0, $urandom() & $urandom());
  endtask

  task automatic test_and_only(input logic [31:0] em);
    int cyc, e, base;
    logic fv;
    logic [4:0] fvec;
    bit ord_ok;
    emap1 = em;
    base = q1.size();
    expect_for(8'b0000_0100, 1'b0, em, e, fv, fvec);
    start_and_wait(1, 100, cyc);
    total++; if (cyc !== 17) begin bad++; $display("FAIL and_latency got=%0d exp=17", cyc); end
    total++; if (ps1 !== (e == 0)) begin bad++; $display("FAIL and_pass got=%b exp=%b", ps1, (e == 0)); end
    total++; if (ec1 !== 6'(e)) begin bad++; $display("FAIL and_err got=%0d exp=%0d", ec1, e); end
    total++; if ({fv1, fvec1} !== {fv, fvec}) begin bad++; $display("FAIL and_fail got=%b/%b exp=%b/%b", fv1, fvec1, fv, fvec); end
    ord_ok = (q1.size() - base == 4);
    if (ord_ok) for (int k = 0; k < 4; k++) if (q1[base + k] != 8 + k) ord_ok = 1'b0;
    total++; if (!ord_ok) begin bad++; $display("FAIL and_order got=%0d vectors exp=8..11", q1.size() - base); end
    total++; if (s1 !== 3'b010) begin bad++; $display("FAIL and_s got=%b exp=010", s1); end
  endtask

  task automatic test_zero_mask();
    int cyc, base;
    for (int r = 0; r < 2; r++) begin
      base = moves2;
      start_and_wait(2, 10, cyc);
      total++; if (cyc !== 1) begin bad++; $display("FAIL zero_latency got=%0d exp=1", cyc); end
      total++; if ({dn2, ps2, ec2} !== {1'b1, 1'b1, 6'd0}) begin bad++; $display("FAIL zero_result got=%b/%b/%0d exp=1/1/0", dn2, ps2, ec2); end
      repeat (2) @(negedge clk);
      #1;
      total++; if (moves2 !== base) begin bad++; $display("FAIL zero_moved got=%0d exp=%0d", moves2, base); end
    end
  endtask

  task automatic test_start_ignored();
    int cyc;
    zero0 = 1'b0; emap0 = '0;
    @(posedge clk); #1;
    st0 = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      st0 = (cyc == 20);
      cyc++;
    end while (!dn0 && cyc < 200);
    st0 = 1'b0;
    total++; if (cyc !== 65) begin bad++; $display("FAIL ignored_latency got=%0d exp=65", cyc); end
    total++; if (ps0 !== 1'b1) begin bad++; $display("FAIL ignored_pass got=%b exp=1", ps0); end
  endtask

  task automatic test_abort();
    // vector 2 faulty: it is checked before the abort lands
    emap0 = 32'h0000_0004;
    @(posedge clk); #1;
    st0 = 1'b1;
    @(posedge clk); #1;
    st0 = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    ab0 = 1'b1;
    @(posedge clk); #1;
    ab0 = 1'b0;
    total++; if ({bz0, dn0, ps0} !== 3'b000) begin bad++; $display("FAIL abort_flags got=%b exp=000", {bz0, dn0, ps0}); end
    total++; if ({s0, a0, b0} !== 5'd0) begin bad++; $display("FAIL abort_vec got=%0d exp=0", {s0, a0, b0}); end
    total++; if ({ec0, fv0, fvec0} !== {6'd1, 1'b1, 5'd2}) begin bad++; $display("FAIL abort_kept got=%0d/%b/%0d exp=1/1/2", ec0, fv0, fvec0); end
    test_full(1'b0, 32'h0);
  endtask

  task automatic test_reset_mid();
    emap0 = 32'h0000_0001;
    @(posedge clk); #1;
    st0 = 1'b1;
    @(posedge clk); #1;
    st0 = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    total++; if ({a0, b0, s0, bz0, dn0, ps0, ec0, fv0, fvec0} !== 20'd0) begin
      bad++; $display("FAIL midreset_outputs got=%h exp=0", {a0, b0, s0, bz0, dn0, ps0, ec0, fv0, fvec0});
    end
    #1;
    rst_n = 1'b1;
    test_full(1'b0, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_full(1'b0, 32'h0);
    test_stuck_zero();
    test_random_errors();
    test_and_only(32'h0);
    test_and_only($urandom());
    test_zero_mask();
    test_start_ignored();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
